// File: rtl/fifo_occupancy_tracker.sv
// fifo_occupancy_tracker: free-entry counter giving registered FIFO status flags and combinational under/overflow errors
module fifo_occupancy_tracker #(
    parameter int depth = 8,
    parameter bit fast_almost_empty = 1'b0,
    parameter bit fast_two_free = 1'b0,
    parameter bit enable_bypass = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       push,
    input  logic       pop,
    output logic       almost_empty,
    output logic       empty,
    output logic       almost_full,
    output logic       full,
    output logic       two_free,
    output logic [1:0] errors
);
    assign errors = {empty & pop & ~(enable_bypass & push), full & push};
    generate
        if (depth < 1) begin : g_bad
            $fatal(1, "fifo_occupancy_tracker: depth must be >= 1");
        end else if (depth == 1) begin : g_one
            always_ff @(posedge clk)
                if (reset) empty <= 1'b1;
                else if (active) empty <= pop ? 1'b1 : push ? 1'b0 : empty;
            assign almost_empty = ~empty;
            assign almost_full = empty;
            assign full = ~empty;
            assign two_free = 1'b0;
        end else begin : g_cnt
            localparam int W = $clog2(depth + 1);
            localparam logic [W-1:0] D = W'(depth);
            logic [W-1:0] free, nfree;
            logic ae_q, tf_q;
            assign nfree = (push & ~pop) ? free - W'(1) : (pop & ~push) ? free + W'(1) : free;
            // empty/full (and the optional fast flags) are pre-decoded from the next count
            always_ff @(posedge clk)
                if (reset) begin
                    free <= D;
                    empty <= 1'b1;
                    full <= 1'b0;
                    ae_q <= 1'b0;
                    tf_q <= 1'b0;
                end else if (active) begin
                    free <= nfree;
                    empty <= nfree == D;
                    full <= nfree == '0;
                    ae_q <= nfree == D - W'(1);
                    tf_q <= nfree == W'(2);
                end
            assign almost_empty = fast_almost_empty ? ae_q : free == D - W'(1);
            assign almost_full = free == W'(1);
            assign two_free = (fast_two_free && depth > 2) ? tf_q : free == W'(2);
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (!reset && errors[1]) $warning("%m: underflow");
        if (!reset && errors[0]) $warning("%m: overflow");
    end
endmodule

// File: tb/tb_fifo_occupancy_tracker.sv
// tb_fifo_occupancy_tracker: directed vectors with a queued scoreboard across several tracker configurations
module tb_fifo_occupancy_tracker;
    logic clk = 1'b0;
    logic reset = 1'b1, active = 1'b0, push = 1'b0, pop = 1'b0;
    logic [4:0][4:0] fl;
    logic [4:0][1:0] er;
    int sel = 0, passed = 0, total = 0;

    typedef struct {
        int s;
        bit ck;
        logic [4:0] f;
        logic [1:0] e;
        string nm;
    } item_t;
    item_t q[$];

    always #5 clk = ~clk;

    fifo_occupancy_tracker #(.depth(8)) u0 (.clk(clk), .reset(reset), .active(active), .push(push), .pop(pop),
        .almost_empty(fl[0][4]), .empty(fl[0][3]), .almost_full(fl[0][2]), .full(fl[0][1]), .two_free(fl[0][0]), .errors(er[0]));
    fifo_occupancy_tracker #(.depth(8), .fast_almost_empty(1'b1), .fast_two_free(1'b1)) u1 (.clk(clk), .reset(reset), .active(active), .push(push), .pop(pop),
        .almost_empty(fl[1][4]), .empty(fl[1][3]), .almost_full(fl[1][2]), .full(fl[1][1]), .two_free(fl[1][0]), .errors(er[1]));
    fifo_occupancy_tracker #(.depth(8), .enable_bypass(1'b1)) u2 (.clk(clk), .reset(reset), .active(active), .push(push), .pop(pop),
        .almost_empty(fl[2][4]), .empty(fl[2][3]), .almost_full(fl[2][2]), .full(fl[2][1]), .two_free(fl[2][0]), .errors(er[2]));
    fifo_occupancy_tracker #(.depth(1)) u3 (.clk(clk), .reset(reset), .active(active), .push(push), .pop(pop),
        .almost_empty(fl[3][4]), .empty(fl[3][3]), .almost_full(fl[3][2]), .full(fl[3][1]), .two_free(fl[3][0]), .errors(er[3]));
    fifo_occupancy_tracker #(.depth(2)) u4 (.clk(clk), .reset(reset), .active(active), .push(push), .pop(pop),
        .almost_empty(fl[4][4]), .empty(fl[4][3]), .almost_full(fl[4][2]), .full(fl[4][1]), .two_free(fl[4][0]), .errors(er[4]));

    // f = {almost_empty, empty, almost_full, full, two_free} visible during this cycle, e = errors for these strobes
    task automatic cyc(input bit r, input bit a, input bit pu, input bit po, input bit ck,
                       input logic [4:0] f, input logic [1:0] e, input string nm);
        @(posedge clk);
        #1;
        reset = r;
        active = a;
        push = pu;
        pop = po;
        q.push_back('{s: sel, ck: ck, f: f, e: e, nm: nm});
    endtask

    task automatic fill8();
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 1, 0, 1, 5'b01000, 2'b00, "push1");
        cyc(0, 1, 1, 0, 1, 5'b10000, 2'b00, "push2");
        cyc(0, 1, 1, 0, 1, 5'b00000, 2'b00, "push3");
        cyc(0, 1, 1, 0, 1, 5'b00000, 2'b00, "push4");
        cyc(0, 1, 1, 0, 1, 5'b00000, 2'b00, "push5");
        cyc(0, 1, 1, 0, 1, 5'b00000, 2'b00, "push6");
        cyc(0, 1, 1, 0, 1, 5'b00001, 2'b00, "push7");
        cyc(0, 1, 1, 0, 1, 5'b00100, 2'b00, "push8");
        cyc(0, 1, 0, 0, 1, 5'b00010, 2'b00, "full");
        cyc(0, 1, 1, 0, 1, 5'b00010, 2'b01, "overflow");
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 0, 1, 1, 5'b01000, 2'b10, "underflow");
    endtask

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                it = q.pop_front();
                if (it.ck) begin
                    total += 2;
                    if (fl[it.s] === it.f) passed++;
                    else $display("FAIL %s flags dut%0d: got %b want %b", it.nm, it.s, fl[it.s], it.f);
                    if (er[it.s] === it.e) passed++;
                    else $display("FAIL %s errors dut%0d: got %b want %b", it.nm, it.s, er[it.s], it.e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0;
        fill8();
        sel = 1;
        fill8();
        sel = 0;
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 1, 0, 1, 5'b01000, 2'b00, "p_push1");
        cyc(0, 1, 1, 0, 1, 5'b10000, 2'b00, "p_push2");
        cyc(0, 1, 1, 0, 1, 5'b00000, 2'b00, "p_push3");
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 1, 5'b00000, 2'b00, "pushpop");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 5'b00000, 2'b00, "inactive_push");
        cyc(0, 1, 0, 1, 1, 5'b00000, 2'b00, "p_pop1");
        cyc(0, 1, 0, 1, 1, 5'b00000, 2'b00, "p_pop2");
        cyc(0, 0, 0, 1, 1, 5'b10000, 2'b00, "inactive_pop");
        cyc(0, 1, 0, 0, 1, 5'b10000, 2'b00, "hold_one");
        sel = 2;
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 1, 1, 1, 5'b01000, 2'b00, "bypass");
        cyc(0, 1, 0, 0, 1, 5'b01000, 2'b00, "bypass_empty");
        sel = 0;
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 1, 1, 1, 5'b01000, 2'b10, "no_bypass");
        sel = 3;
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 1, 0, 1, 5'b01100, 2'b00, "d1_push");
        cyc(0, 1, 0, 0, 1, 5'b10010, 2'b00, "d1_full");
        cyc(0, 1, 0, 1, 1, 5'b10010, 2'b00, "d1_pop");
        cyc(0, 1, 1, 0, 1, 5'b01100, 2'b00, "d1_push2");
        cyc(1, 1, 0, 0, 1, 5'b10010, 2'b00, "d1_rst_mid");
        cyc(0, 1, 0, 0, 1, 5'b01100, 2'b00, "d1_after_rst");
        cyc(0, 1, 1, 0, 1, 5'b01100, 2'b00, "d1_push3");
        cyc(0, 1, 1, 0, 1, 5'b10010, 2'b01, "d1_overflow");
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 0, 1, 1, 5'b01100, 2'b10, "d1_underflow");
        sel = 4;
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        cyc(0, 1, 1, 0, 1, 5'b01001, 2'b00, "d2_push1");
        cyc(0, 1, 1, 0, 1, 5'b10100, 2'b00, "d2_push2");
        cyc(0, 1, 0, 0, 1, 5'b00010, 2'b00, "d2_full");
        cyc(0, 1, 0, 1, 1, 5'b00010, 2'b00, "d2_pop1");
        cyc(0, 1, 1, 1, 1, 5'b10100, 2'b00, "d2_pushpop");
        cyc(0, 1, 0, 1, 1, 5'b10100, 2'b00, "d2_pop2");
        cyc(0, 1, 1, 0, 1, 5'b01001, 2'b00, "d2_push3");
        cyc(1, 1, 0, 0, 1, 5'b10100, 2'b00, "d2_rst_mid");
        cyc(0, 1, 0, 0, 1, 5'b01001, 2'b00, "d2_after_rst");
        cyc(0, 1, 0, 1, 1, 5'b01001, 2'b10, "d2_underflow");
        cyc(1, 1, 0, 0, 0, 5'b00000, 2'b00, "rst");
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d items left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fifo_occupancy_tracker.md
Name: fifo_occupancy_tracker

Overview:
- Tracks the occupancy of a FIFO of `depth` entries from push/pop strobes; it holds no data.
- Provides registered empty/full status and near-boundary status flags, plus combinational underflow/overflow error flags.
- Used beside FIFO storage and credit counters in router/buffer logic.
- Built from the codebase's incrementer, decrementer and enabled flip-flop primitives.

Parameters:
- depth, 8: number of FIFO entries; must be >= 1. Simulation must fatal-stop if depth < 1.
- fast_almost_empty, 0: 1 = almost_empty comes from a dedicated flop instead of a count decode.
- fast_two_free, 0: 1 = two_free comes from a dedicated flop instead of a count decode (applies when depth > 2).
- enable_bypass, 0: 1 = push & pop on an empty FIFO is legal (bypass).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- active  in  1  clock enable; when 0, all state holds.
- push  in  1  add one entry this cycle.
- pop  in  1  remove one entry this cycle.
- almost_empty  out  1  exactly one entry occupied.
- empty  out  1  no entries occupied.
- almost_full  out  1  exactly one entry free.
- full  out  1  all entries occupied.
- two_free  out  1  exactly two entries free.
- errors  out  2  {underflow, overflow}; underflow is the MSB.

Behaviour:
- State is a free-entry count `free`, width clog2(depth+1), range 0..depth.
- Reset (synchronous, overrides active): free=depth, so empty=1 and all other flags are 0. Exception: for depth==1, almost_full=1; for depth==2, two_free=1.
- Each rising edge with reset=0 and active=1:
  - push & ~pop: free-1.
  - pop & ~push: free+1.
  - push & pop, or neither: free unchanged.
- When active=0, free and all flag flops hold.
- Flags are registered state, valid the cycle after the update edge. They must always equal their decode of the current count:
  - empty: free==depth.
  - almost_empty: free==depth-1.
  - almost_full: free==1.
  - full: free==0.
  - two_free: free==2.
- empty and full are always dedicated flops, computed from the next count, with no combinational path from push/pop.
- The fast_* options change timing only; port behaviour is identical.
- depth==1: a single empty flop.
  - pop sets it; otherwise push clears it.
  - almost_empty=~empty, almost_full=empty, full=~empty, two_free=0.
- depth==2: almost_full = almost_empty; two_free = empty.
- errors, combinational, same cycle as the strobes:
  - underflow = empty & pop & ~(enable_bypass & push).
  - overflow = full & push. This holds even with a simultaneous pop.
- Legal simultaneous push & pop: any non-empty, non-full state, or empty with enable_bypass=1. Count is unchanged.
- After an error cycle, state is undefined until reset. Verification stops checking flags until the next reset.
- Simulation-only: print an error message naming the instance on each underflow/overflow edge.

Test Plan:
- depth=8, reset, then 8 pushes → empty falls after push 1; almost_empty=1 after push 1 only; two_free=1 after push 6; almost_full=1 after push 7; full=1 after push 8; errors=00 throughout.
- From full, push=1 → errors=01 in the same cycle; then from empty, pop=1 → errors=10.
- depth=8, occupancy 3, push&pop for 4 cycles → flags unchanged; then active=0 with push=1 for 3 cycles → flags unchanged.
- enable_bypass=1, empty, push&pop → errors=00 and empty stays 1. Repeat with enable_bypass=0 → errors=10.
- depth=1 and depth=2, push/pop sequences → flag equalities as specified; two_free=0 for depth=1; reset asserted mid-sequence → empty=1 on the next cycle.
- Repeat scenario 1 with fast_almost_empty=1 and fast_two_free=1 → cycle-identical outputs.
